multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder; drives the shared-memory, shared-ALU MIPS datapath one step per clock.
- Sits between the instruction register opcode field and the datapath muxes and enables.
- Adds a memory-ready handshake, illegal-opcode trapping and a retired-instruction counter.
- Supports R-type, lw, sw, beq, bne, j, addi and andi.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- HALT_ON_ILLEGAL, 0: 1 = the ILLEGAL state is terminal until reset; 0 = one cycle in ILLEGAL, then FETCH.
- ENABLE_BNE, 1: 0 = opcode 000101 decodes as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (beq).
- PCWriteCondNe  out  1  PC load if not ALU zero (bne).
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- MemtoReg, RegDst, RegWrite  out  1 each  register-file write controls.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = and.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state code (debug).
- instr_done  out  1  one-cycle pulse on an instruction's final cycle.
- illegal_op  out  1  high while in ILLEGAL.
- retired_count  out  CNT_W  number of retired instructions.

Behaviour:
- Moore FSM; outputs are combinational from the state register (plus mem_ready where noted). Unlisted outputs are 0.
- Sync reset (rst_n low at a clock edge):
  - state = IDLE(0), retired_count = 0, opcode latch = 0.
  - In IDLE every output is 0.
  - A mid-instruction reset aborts the instruction with no retire; any partially issued write stays de-asserted from that edge onward.
- State codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, REXEC 7, RWB 8, BEQ 9, BNE 10, JUMP 11, IEXEC 12, IWB 13, ILLEGAL 14. Code 15 is unreachable; if entered, go to IDLE.
- IDLE: always goes to FETCH next cycle.
- FETCH:
  - MemRead=1; ALUSrcB=01; ALUOp=00; PCSource=00.
  - IRWrite = PCWrite = mem_ready(eff).
  - Stays in FETCH while mem_ready(eff)=0; goes to DECODE when it is 1.
- DECODE:
  - ALUSrcB=11; ALUOp=00.
  - Latches opcode.
  - Next state by opcode: 000000 → REXEC; 100011/101011 → MEMADR; 000100 → BEQ; 000101 → BNE (or ILLEGAL if ENABLE_BNE=0); 000010 → JUMP; 001000/001100 → IEXEC; anything else → ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=10; next state MEMRD if latched opcode is lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1; waits for mem_ready(eff), then MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, RegDst=0 → FETCH.
- MEMWR: MemWrite=1, IorD=1; waits for mem_ready(eff), then FETCH. It retires on the cycle mem_ready(eff)=1.
- REXEC: ALUSrcA=1, ALUOp=10 → RWB.
- RWB: RegDst=1, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- BNE: same as BEQ but asserts PCWriteCondNe instead of PCWriteCond → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10; ALUOp=00 for addi, 11 for andi (from the latched opcode) → IWB.
- IWB: RegWrite=1, RegDst=0 → FETCH.
- ILLEGAL: illegal_op=1; no write strobes; not counted as retired; next state FETCH, or stays in ILLEGAL if HALT_ON_ILLEGAL=1.
- Retirement:
  - instr_done=1 in MEMWB, RWB, BEQ, BNE, JUMP, IWB, and in MEMWR on its completing cycle.
  - retired_count increments on the same edge and wraps from 2^CNT_W-1 to 0.
- Instruction latencies with mem_ready always high: lw 5 cycles; sw, R-type, addi, andi 4; beq, bne, j 3.
- A mem_ready pulse outside FETCH, MEMRD and MEMWR is ignored.

Test Plan:
- Reset, then R-type 000000, mem_ready=1 → states 0,1,2,7,8,1; RegDst=1 and RegWrite=1 in RWB; retired_count=1.
- lw 100011 with mem_ready low for 3 cycles in MEMRD → MemRead/IorD held for 4 cycles; MEMWB has MemtoReg=1; total 8 cycles; instr_done is a single pulse.
- Sequence beq, bne, j, andi → PCWriteCond, PCWriteCondNe, PCWrite+PCSource=10, then ALUOp=11 in IEXEC; retired_count=4.
- Opcode 111111 with HALT_ON_ILLEGAL=0 → ILLEGAL for 1 cycle, illegal_op=1, no count change. With HALT_ON_ILLEGAL=1 → stays in state 14 until rst_n low. With ENABLE_BNE=0, bne → ILLEGAL.
- rst_n low for one edge while in MEMWR → next state IDLE; MemWrite=0; retired_count=0.
- CNT_W=4 with 16 addi instructions → count 15 then wraps to 0. With MEM_HANDSHAKE=0 and mem_ready held 0 → no wait states.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore control FSM for the shared-memory multi-cycle MIPS datapath,
//            with memory handshake, illegal-opcode trap and retire counter.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int CNT_W           = 32,
    parameter int MEM_HANDSHAKE   = 1,
    parameter int HALT_ON_ILLEGAL = 0,
    parameter int ENABLE_BNE      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [3:0] c_S_IDLE    = 4'd0;
    localparam logic [3:0] c_S_FETCH   = 4'd1;
    localparam logic [3:0] c_S_DECODE  = 4'd2;
    localparam logic [3:0] c_S_MEMADR  = 4'd3;
    localparam logic [3:0] c_S_MEMRD   = 4'd4;
    localparam logic [3:0] c_S_MEMWB   = 4'd5;
    localparam logic [3:0] c_S_MEMWR   = 4'd6;
    localparam logic [3:0] c_S_REXEC   = 4'd7;
    localparam logic [3:0] c_S_RWB     = 4'd8;
    localparam logic [3:0] c_S_BEQ     = 4'd9;
    localparam logic [3:0] c_S_BNE     = 4'd10;
    localparam logic [3:0] c_S_JUMP    = 4'd11;
    localparam logic [3:0] c_S_IEXEC   = 4'd12;
    localparam logic [3:0] c_S_IWB     = 4'd13;
    localparam logic [3:0] c_S_ILLEGAL = 4'd14;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [5:0]       r_opcode;
    logic [CNT_W-1:0] r_retired;
    logic             w_mem_rdy;

    assign w_mem_rdy     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state         = r_state;
    assign retired_count = r_retired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_S_IDLE;
            r_opcode  <= 6'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_S_DECODE) begin
                r_opcode <= opcode;
            end
            if (instr_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next = c_S_IDLE;
        case (r_state)
            c_S_IDLE:   w_next = c_S_FETCH;
            c_S_FETCH:  w_next = w_mem_rdy ? c_S_DECODE : c_S_FETCH;
            c_S_DECODE: begin
                case (opcode)
                    c_OP_RTYPE:         w_next = c_S_REXEC;
                    c_OP_LW, c_OP_SW:   w_next = c_S_MEMADR;
                    c_OP_BEQ:           w_next = c_S_BEQ;
                    c_OP_BNE:           w_next = (ENABLE_BNE != 0) ? c_S_BNE : c_S_ILLEGAL;
                    c_OP_J:             w_next = c_S_JUMP;
                    c_OP_ADDI, c_OP_ANDI: w_next = c_S_IEXEC;
                    default:            w_next = c_S_ILLEGAL;
                endcase
            end
            c_S_MEMADR:  w_next = (r_opcode == c_OP_LW) ? c_S_MEMRD : c_S_MEMWR;
            c_S_MEMRD:   w_next = w_mem_rdy ? c_S_MEMWB : c_S_MEMRD;
            c_S_MEMWB:   w_next = c_S_FETCH;
            c_S_MEMWR:   w_next = w_mem_rdy ? c_S_FETCH : c_S_MEMWR;
            c_S_REXEC:   w_next = c_S_RWB;
            c_S_RWB:     w_next = c_S_FETCH;
            c_S_BEQ:     w_next = c_S_FETCH;
            c_S_BNE:     w_next = c_S_FETCH;
            c_S_JUMP:    w_next = c_S_FETCH;
            c_S_IEXEC:   w_next = c_S_IWB;
            c_S_IWB:     w_next = c_S_FETCH;
            c_S_ILLEGAL: w_next = (HALT_ON_ILLEGAL != 0) ? c_S_ILLEGAL : c_S_FETCH;
            default:     w_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_mem_rdy;
                PCWrite = w_mem_rdy;
            end
            c_S_DECODE: ALUSrcB = 2'b11;
            c_S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            c_S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = w_mem_rdy;
            end
            c_S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            c_S_RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            c_S_BNE: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCWriteCondNe = 1'b1;
                PCSource      = 2'b01;
                instr_done    = 1'b1;
            end
            c_S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            c_S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (r_opcode == c_OP_ANDI) ? 2'b11 : 2'b00;
            end
            c_S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
